lane_combine_fifo: RTL and testbench
====================================

// Module: lane_combine_fifo
// PURPOSE
//  Splits a packed input word into NLANES lanes of LW bits and combines each adjacent lane pair.
//  - Output lane k = OP(lane k, lane k+1), for k = 0 .. NLANES-2.
//  - OP is selected per beat: AND, OR, XOR or XNOR.
//  - Results are buffered in a DEPTH-entry FIFO behind valid/ready handshakes on both sides.
//  - Generalised, streaming successor of the fixed 3-lane nibble AND slice used in sv cosim benches.
// PARAMETERS
//  LW      4   lane width in bits (>=1)
//  NLANES  3   number of input lanes (>=2)
//  DEPTH   2   result FIFO entries (>=1)
//  CW      16  width of the beat counter
// PORTS
//  clk        in   1               clock; all state updates on posedge
//  rst        in   1               synchronous reset, active-high
//  in_valid   in   1               input beat offered
//  in_ready   out  1               block can accept a beat
//  in_data    in   NLANES*LW       lane k = in_data[k*LW +: LW]
//  in_mode    in   2               00 AND, 01 OR, 10 XOR, 11 XNOR; sampled with the beat
//  out_valid  out  1               FIFO head valid
//  out_ready  in   1               consumer accepts head
//  out_data   out  (NLANES-1)*LW   lane k = out_data[k*LW +: LW]
//  out_level  out  $clog2(DEPTH+1) FIFO occupancy
//  beat_cnt   out  CW              count of accepted input beats; wraps
// BEHAVIOUR
//  - Reset (rst=1 at posedge), dominant over any handshake in the same cycle:
//    - FIFO emptied; out_valid=0, out_level=0, beat_cnt=0, out_data=0.
//    - in_ready=0 while rst=1, and 1 in the first cycle after.
//  - Push: occurs when in_valid & in_ready.
//    - Lane results are computed combinationally from in_data and in_mode.
//    - Results are written into the FIFO tail in the same edge.
//    - beat_cnt increments by 1, modulo 2^CW; all-ones wraps to 0.
//  - Pop: occurs when out_valid & out_ready; the head advances.
//  - Latency: beat accepted at edge t into an empty FIFO gives out_valid=1 and data visible after edge t.
//    - No combinational path from in_data to out_data.
//  - in_ready = (out_level < DEPTH) | (out_valid & out_ready).
//    - When full, a simultaneous pop allows a push in the same cycle.
//    - Level is then unchanged and ordering is preserved.
//  - Empty with in_valid: no bypass; a beat is never pushed and popped in the same cycle.
//  - out_data is only defined while out_valid=1; it holds the head entry until popped.
//  - in_mode is ignored when no push occurs.
//    - Each FIFO entry carries the result computed with the mode of its own beat.
//  - Pointers wrap modulo DEPTH; non-power-of-2 DEPTH is supported.
//  - Protocol: once out_valid rises it holds, and the head is stable, until popped or reset.
// CONFIGURATION
//  - LANE_COMBINE_PARITY_EN defined:
//    - Adds output port out_parity (1 bit) = XOR reduction of the entry's out_data bits.
//    - Parity is computed at push time, stored per FIFO entry, and is 0 at reset.
//  - Not defined: port and storage are absent; all other behaviour is identical.
// TESTING  (LW=4, NLANES=3, DEPTH=2 unless noted)
//  1. in_data=12'hF3C, in_mode=00, out_ready=1 -> one cycle later out_valid=1, out_data=8'h30; beat_cnt=1.
//  2. Same data, modes 01, 10, 11 back-to-back, out_ready=1 -> out_data 8'hFF, 8'hCF, 8'h30 in order.
//  3. out_ready=0, push 3 beats -> 2 accepted, in_ready=0, out_level=2.
//     Then out_ready=1 with in_valid=1 -> push and pop in the same cycle, level stays 2, order kept.
//  4. rst=1 while out_level=2 and in_valid=1 -> next cycle out_valid=0, out_level=0, beat_cnt=0.
//     The concurrent beat is dropped.
//  5. CW=4: 17 accepted beats -> beat_cnt reads 1 (wrap at 16).
//  6. LANE_COMBINE_PARITY_EN, XOR mode, in_data=12'hF3C -> out_data=8'hCF, out_parity=0.
//     With in_data=12'h01C -> out_data=8'h1D, out_parity=0; with in_data=12'h00C -> 8'h0C, out_parity=0.
//     With in_data=12'h008 -> 8'h08, out_parity=1.

Source files
------------

// File: rtl/lane_combine_fifo.sv
// lane_combine_fifo: combines adjacent lane pairs of a packed input beat
// (AND/OR/XOR/XNOR, chosen per beat) and buffers the results in a FIFO.
// Ports: clk, rst (sync, active-high)
//   in_valid/in_ready/in_data/in_mode : input beat handshake + operation
//   out_valid/out_ready/out_data      : FIFO head handshake
//   out_level : FIFO occupancy, beat_cnt : accepted beats (wraps)
// Option: `define LANE_COMBINE_PARITY_EN adds out_parity (XOR of out_data).
module lane_combine_fifo #(
  parameter int LW     = 4,
  parameter int NLANES = 3,
  parameter int DEPTH  = 2,
  parameter int CW     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NLANES*LW-1:0]         in_data,
  input  logic [1:0]                   in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(NLANES-1)*LW-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0]   out_level,
  output logic [CW-1:0]                beat_cnt
`ifdef LANE_COMBINE_PARITY_EN
  ,
  output logic                         out_parity
`endif
);

  localparam int OW  = (NLANES-1)*LW;
  localparam int LVW = $clog2(DEPTH+1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [OW-1:0]  r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [LVW-1:0] r_level;
  logic [CW-1:0]  r_cnt;

  logic [OW-1:0]  w_res;
  logic           w_full;
  logic           w_push;
  logic           w_pop;

  // wrap explicitly so non-power-of-2 depths work
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_res = '0;
    for (int k = 0; k < NLANES-1; k++) begin
      unique case (in_mode)
        2'b00: w_res[k*LW +: LW] =
          in_data[k*LW +: LW] & in_data[(k+1)*LW +: LW];
        2'b01: w_res[k*LW +: LW] =
          in_data[k*LW +: LW] | in_data[(k+1)*LW +: LW];
        2'b10: w_res[k*LW +: LW] =
          in_data[k*LW +: LW] ^ in_data[(k+1)*LW +: LW];
        2'b11: w_res[k*LW +: LW] =
          ~(in_data[k*LW +: LW] ^ in_data[(k+1)*LW +: LW]);
        default: w_res[k*LW +: LW] = '0;
      endcase
    end
  end

  assign w_full    = (r_level == LVW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid & out_ready;
  // a pop frees the slot in the same cycle, so a full FIFO can still accept
  assign in_ready  = ~rst & (~w_full | w_pop);
  assign w_push    = in_valid & in_ready;
  assign out_data  = r_mem[r_head];
  assign out_level = r_level;
  assign beat_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_res;
        r_tail        <= nxt(r_tail);
        r_cnt         <= r_cnt + 1'b1;
      end
      if (w_pop) r_head <= nxt(r_head);
      if (w_push & ~w_pop)
        r_level <= r_level + 1'b1;
      else if (~w_push & w_pop)
        r_level <= r_level - 1'b1;
    end
  end

`ifdef LANE_COMBINE_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
    end else if (w_push) begin
      r_par[r_tail] <= ^w_res;
    end
  end

  assign out_parity = r_par[r_head];
`endif

endmodule

// File: tb/tb_lane_combine_fifo.sv
// tb_lane_combine_fifo: directed + randomized bench against a queue model.
// A second CW=4 instance shares the stimulus to exercise counter wrap.
module tb_lane_combine_fifo;

  localparam int LW = 4;
  localparam int NL = 3;
  localparam int D  = 2;
  localparam int IW = NL*LW;
  localparam int OW = (NL-1)*LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [1:0]    out_level;
  logic [15:0]   beat_cnt;

  logic          in_ready4;
  logic          out_valid4;
  logic [OW-1:0] out_data4;
  logic [1:0]    out_level4;
  logic [3:0]    beat_cnt4;

`ifdef LANE_COMBINE_PARITY_EN
  logic          out_parity;
  logic          out_parity4;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cnt   = 0;
  logic [OW-1:0] q[$];

  always #5 clk = ~clk;

  lane_combine_fifo #(.LW(LW), .NLANES(NL), .DEPTH(D), .CW(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_level(out_level),
    .beat_cnt(beat_cnt)
`ifdef LANE_COMBINE_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  lane_combine_fifo #(.LW(LW), .NLANES(NL), .DEPTH(D), .CW(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_level(out_level4),
    .beat_cnt(beat_cnt4)
`ifdef LANE_COMBINE_PARITY_EN
    , .out_parity(out_parity4)
`endif
  );

  // lane-pair combine from plain integer arithmetic
  function automatic logic [OW-1:0] ref_comb(input int d, input int m);
    int a, b, r, res;
    res = 0;
    for (int k = 0; k < NL-1; k++) begin
      a = (d >> (k*LW)) % (1 << LW);
      b = (d >> ((k+1)*LW)) % (1 << LW);
      case (m)
        0: r = a & b;
        1: r = a | b;
        2: r = a ^ b;
        default: r = (~(a ^ b)) & ((1 << LW) - 1);
      endcase
      res = res + (r << (k*LW));
    end
    return OW'(res);
  endfunction

  function automatic bit ref_rdy();
    return !rst && (q.size() < D || (q.size() > 0 && out_ready));
  endfunction

  task automatic tick();
    bit push, pop;
    push = in_valid && ref_rdy();
    pop  = out_ready && q.size() > 0;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(ref_comb(int'(in_data), int'(in_mode)));
        cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; out_ready = 0;
    in_data = IW'($urandom); in_mode = 2'($urandom);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    tick();
    tick();
    rst = 0; in_valid = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    n_vec++;
    if (out_level !== 2'd0 || beat_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_state level %0d cnt %0d want 0 0",
               out_level, beat_cnt);
    end
    n_vec++;
    if (out_data !== 8'h00) begin
      n_bad++; $display("FAIL rst_out_data got %h want 00", out_data);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_modes();
    logic [7:0] exp_m [4];
    exp_m = '{8'h30, 8'hFF, 8'hCF, 8'h30};
    out_ready = 1; in_valid = 1; in_data = 12'hF3C; in_mode = 2'b00;
    #1;
    tick();
    in_valid = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== exp_m[0]) begin
      n_bad++;
      $display("FAIL mode_and valid %b data %h want 1 %h",
               out_valid, out_data, exp_m[0]);
    end
    n_vec++;
    if (beat_cnt !== 16'd1) begin
      n_bad++; $display("FAIL mode_cnt got %0d want 1", beat_cnt);
    end
    for (int i = 1; i < 4; i++) begin
      in_valid = 1; in_mode = 2'(i);
      #1;
      tick();
      n_vec++;
      if (out_data !== exp_m[i] || out_level !== 2'd1) begin
        n_bad++;
        $display("FAIL mode_%0d data %h lvl %0d want %h 1",
                 i, out_data, out_level, exp_m[i]);
      end
    end
    in_valid = 0;
    #1;
    tick();
  endtask

  task automatic test_full();
    logic [OW-1:0] e2;
    logic [OW-1:0] e3;
    out_ready = 0; in_valid = 1;
    e2 = '0;
    for (int i = 0; i < 3; i++) begin
      in_data = IW'($urandom); in_mode = 2'($urandom);
      if (i == 1) e2 = ref_comb(int'(in_data), int'(in_mode));
      #1;
      if (i == 2) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_bad++; $display("FAIL full_ready got %b want 0", in_ready);
        end
      end
      tick();
    end
    #1;
    n_vec++;
    if (out_level !== 2'd2) begin
      n_bad++; $display("FAIL full_level got %0d want 2", out_level);
    end
    out_ready = 1;
    in_data = IW'($urandom); in_mode = 2'($urandom);
    e3 = ref_comb(int'(in_data), int'(in_mode));
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL full_pop_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 0; out_ready = 0;
    #1;
    n_vec++;
    if (out_level !== 2'd2 || out_data !== e2) begin
      n_bad++;
      $display("FAIL full_swap lvl %0d data %h want 2 %h",
               out_level, out_data, e2);
    end
    out_ready = 1;
    #1;
    tick();
    out_ready = 0;
    #1;
    n_vec++;
    if (out_data !== e3 || out_level !== 2'd1) begin
      n_bad++;
      $display("FAIL full_order data %h lvl %0d want %h 1",
               out_data, out_level, e3);
    end
    in_valid = 1; in_data = IW'($urandom);
    #1;
    tick();
  endtask

  task automatic test_reset_dominant();
    rst = 1; in_valid = 1; out_ready = 1;
    in_data = IW'($urandom);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rstdom_ready got %b want 0", in_ready);
    end
    tick();
    rst = 0; in_valid = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_level !== 2'd0) begin
      n_bad++;
      $display("FAIL rstdom_state valid %b lvl %0d want 0 0",
               out_valid, out_level);
    end
    n_vec++;
    if (beat_cnt !== 16'd0 || beat_cnt4 !== 4'd0) begin
      n_bad++;
      $display("FAIL rstdom_cnt got %0d %0d want 0 0", beat_cnt, beat_cnt4);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1;
      in_data = IW'($urandom); in_mode = 2'($urandom);
      #1;
      tick();
    end
    in_valid = 0;
    #1;
    n_vec++;
    if (beat_cnt4 !== 4'd1) begin
      n_bad++; $display("FAIL wrap_cnt4 got %0d want 1", beat_cnt4);
    end
    n_vec++;
    if (beat_cnt !== 16'(cnt) || cnt != 17) begin
      n_bad++;
      $display("FAIL wrap_cnt16 got %0d want %0d", beat_cnt, cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = IW'($urandom);
      in_mode   = 2'($urandom);
      #1;
      n_vec++;
      if (in_ready !== ref_rdy()) begin
        n_bad++;
        $display("FAIL rnd_ready c%0d got %b want %b", c, in_ready, ref_rdy());
      end
      n_vec++;
      if (out_level !== 2'(q.size()) || out_valid !== (q.size() > 0)) begin
        n_bad++;
        $display("FAIL rnd_level c%0d got %0d/%b want %0d",
                 c, out_level, out_valid, q.size());
      end
      if (q.size() > 0) begin
        n_vec++;
        if (out_data !== q[0]) begin
          n_bad++;
          $display("FAIL rnd_data c%0d got %h want %h", c, out_data, q[0]);
        end
`ifdef LANE_COMBINE_PARITY_EN
        n_vec++;
        if (out_parity !== ^q[0]) begin
          n_bad++;
          $display("FAIL rnd_parity c%0d got %b want %b",
                   c, out_parity, ^q[0]);
        end
`endif
      end
      n_vec++;
      if (beat_cnt !== 16'(cnt) || beat_cnt4 !== 4'(cnt)) begin
        n_bad++;
        $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d",
                 c, beat_cnt, beat_cnt4, cnt);
      end
      tick();
    end
  endtask

`ifdef LANE_COMBINE_PARITY_EN
  task automatic test_parity();
    logic [11:0] pd [4];
    logic [7:0]  po [4];
    logic        pp [4];
    pd = '{12'hF3C, 12'h01C, 12'h00C, 12'h008};
    po = '{8'hCF, 8'h1D, 8'h0C, 8'h08};
    pp = '{1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1; in_mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = pd[i];
      #1;
      tick();
      in_valid = 0;
      #1;
      n_vec++;
      if (out_data !== po[i] || out_parity !== pp[i]) begin
        n_bad++;
        $display("FAIL parity_%0d data %h par %b want %h %b",
                 i, out_data, out_parity, po[i], pp[i]);
      end
    end
    tick();
  endtask
`endif

  initial begin
    rst = 1; in_valid = 0; out_ready = 0;
    in_data = '0; in_mode = '0;
    @(negedge clk);
    test_reset();
    test_modes();
    test_full();
    test_reset_dominant();
    test_wrap();
`ifdef LANE_COMBINE_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
